lsu: RTL and testbench

Load-store unit and data memory for the single-cycle RV32I core. Sits directly downstream of the ALU: the ALU result is the effective address, rs2 supplies store data, and the aligned, extended load result goes to the writeback mux. Holds the word-addressed data memory, the memory-mapped I/O output registers and the switch-input synchronizer.

---
 rtl/lsu.sv | 122 ++++++++++++
 tb/tb_lsu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load-store unit: word-addressed data memory, LED/LCD output registers
// and a two-stage switch synchronizer behind a single byte-addressed port.
module lsu #(
    parameter int unsigned DMEM_DEPTH = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_lcd
);
    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    logic [31:0]   dmem_q [DMEM_DEPTH];
    logic [31:0]   ledr_q, ledr_d;
    logic [31:0]   ledg_q, ledg_d;
    logic [31:0]   lcd_q, lcd_d;
    logic [31:0]   sw_meta_q, sw_sync_q;

    logic [AW-1:0] widx;
    logic [4:0]    bsh;
    logic          sel_dmem, sel_ledr, sel_ledg, sel_lcd, sel_sw;
    logic          f3_ok, misaligned;
    logic [31:0]   rd_word, lane, ld_ext;
    logic [31:0]   be_mask, st_rep, st_word;
    logic          st_en, dmem_we;

    assign widx = i_lsu_addr[AW+1:2];
    assign bsh  = {i_lsu_addr[1:0], 3'b000};

    always_comb begin
        sel_dmem = (i_lsu_addr[31:AW+2] == '0);
        sel_ledr = (i_lsu_addr[31:12] == 20'h1_0000);
        sel_ledg = (i_lsu_addr[31:12] == 20'h1_0001);
        sel_lcd  = (i_lsu_addr[31:12] == 20'h1_0003);
        sel_sw   = (i_lsu_addr[31:12] == 20'h1_0010);

        // Unsigned sizes have no store form, so they are illegal with wren.
        case (i_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !i_lsu_wren;
            default:                f3_ok = 1'b0;
        endcase
        misaligned = !f3_ok
                   || (i_funct3[1:0] == 2'b01 && i_lsu_addr[0])
                   || (i_funct3 == 3'b010 && i_lsu_addr[1:0] != 2'b00);

        rd_word = '0;
        if (sel_dmem)      rd_word = dmem_q[widx];
        else if (sel_ledr) rd_word = ledr_q;
        else if (sel_ledg) rd_word = ledg_q;
        else if (sel_lcd)  rd_word = lcd_q;
        else if (sel_sw)   rd_word = sw_sync_q;

        lane = rd_word >> bsh;
        case (i_funct3)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b010:  ld_ext = rd_word;
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = '0;
        endcase

        case (i_funct3[1:0])
            2'b00: begin
                be_mask = 32'h0000_00FF << bsh;
                st_rep  = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                be_mask = 32'h0000_FFFF << {i_lsu_addr[1], 4'b0000};
                st_rep  = {2{i_st_data[15:0]}};
            end
            default: begin
                be_mask = '1;
                st_rep  = i_st_data;
            end
        endcase
        // Partial stores merge into the currently addressed word.
        st_word = (rd_word & ~be_mask) | (st_rep & be_mask);
        st_en   = i_lsu_wren && !misaligned;

        ledr_d  = (st_en && sel_ledr) ? st_word : ledr_q;
        ledg_d  = (st_en && sel_ledg) ? st_word : ledg_q;
        lcd_d   = (st_en && sel_lcd)  ? st_word : lcd_q;
        dmem_we = st_en && sel_dmem && !i_reset;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_q    <= '0;
            ledg_q    <= '0;
            lcd_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            ledr_q    <= ledr_d;
            ledg_q    <= ledg_d;
            lcd_q     <= lcd_d;
            sw_meta_q <= i_io_sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Data memory survives reset; only the write is gated by it.
    always_ff @(posedge i_clk) begin
        if (dmem_we) dmem_q[widx] <= st_word;
    end

    assign o_ld_data    = misaligned ? '0 : ld_ext;
    assign o_misaligned = misaligned;
    assign o_io_ledr    = ledr_q;
    assign o_io_ledg    = ledg_q;
    assign o_io_lcd     = lcd_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for loads/stores plus hand
// sequences for async reset and the switch synchronizer.
module tb_lsu;
    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] ld_data;
    logic        mis;
    logic [31:0] sw;
    logic [31:0] ledr, ledg, lcd;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] st;
        logic        wren;
        logic [2:0]  f3;
        logic        chk_ld;
        logic [31:0] exp_ld;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    lsu #(.DMEM_DEPTH(2048)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_lsu_addr(addr),
        .i_st_data(st_data),
        .i_lsu_wren(wren),
        .i_funct3(f3),
        .o_ld_data(ld_data),
        .o_misaligned(mis),
        .i_io_sw(sw),
        .o_io_ledr(ledr),
        .o_io_ledg(ledg),
        .o_io_lcd(lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void add(input string n, input logic [31:0] a,
                                input logic [31:0] d, input logic w,
                                input logic [2:0] f, input logic c,
                                input logic [31:0] e, input logic m);
        vec_t v;
        v.name = n; v.addr = a; v.st = d; v.wren = w; v.f3 = f;
        v.chk_ld = c; v.exp_ld = e; v.exp_mis = m;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        @(negedge clk);
        addr = v.addr; st_data = v.st; wren = v.wren; f3 = v.f3;
        #1;
        if (v.chk_ld) check({v.name, "_ld"}, ld_data, v.exp_ld);
        check({v.name, "_mis"}, {31'b0, mis}, {31'b0, v.exp_mis});
    endtask

    initial begin
        rst = 1'b1; addr = '0; st_data = '0; wren = 1'b0; f3 = 3'b010;
        sw = 32'h1234_5678;
        #1;
        check("rst_ledr", ledr, 32'h0);
        check("rst_ledg", ledg, 32'h0);
        check("rst_lcd", lcd, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //   name       addr          st          w  f3     c  exp_ld       mis
        add("sw0",      32'h10, 32'h0,        1, 3'b010, 0, 32'h0,        0);
        add("sb80",     32'h13, 32'h80,       1, 3'b000, 1, 32'h0,        0);
        add("lw10a",    32'h10, 32'h0,        0, 3'b010, 1, 32'h8000_0000,0);
        add("lb13",     32'h13, 32'h0,        0, 3'b000, 1, 32'hFFFF_FF80,0);
        add("lbu13",    32'h13, 32'h0,        0, 3'b100, 1, 32'h0000_0080,0);
        add("sh12",     32'h12, 32'h5678,     1, 3'b001, 1, 32'hFFFF_8000,0);
        add("lhu12",    32'h12, 32'h0,        0, 3'b101, 1, 32'h0000_5678,0);
        add("lh12",     32'h12, 32'h0,        0, 3'b001, 1, 32'h0000_5678,0);
        add("lw10b",    32'h10, 32'h0,        0, 3'b010, 1, 32'h5678_0000,0);
        add("swdb",     32'h10, 32'hDEADBEEF, 1, 3'b010, 1, 32'h5678_0000,0);
        add("lw10c",    32'h10, 32'h0,        0, 3'b010, 1, 32'hDEAD_BEEF,0);
        add("lb10",     32'h10, 32'h0,        0, 3'b000, 1, 32'hFFFF_FFEF,0);
        add("lbu11",    32'h11, 32'h0,        0, 3'b100, 1, 32'h0000_00BE,0);
        add("lh12b",    32'h12, 32'h0,        0, 3'b001, 1, 32'hFFFF_DEAD,0);
        add("lhu10",    32'h10, 32'h0,        0, 3'b101, 1, 32'h0000_BEEF,0);
        add("sw20",     32'h20, 32'hCAFEF00D, 1, 3'b010, 0, 32'h0,        0);
        add("sh21mis",  32'h21, 32'h1234,     1, 3'b001, 1, 32'h0,        1);
        add("lw20a",    32'h20, 32'h0,        0, 3'b010, 1, 32'hCAFE_F00D,0);
        add("lh21mis",  32'h21, 32'h0,        0, 3'b001, 1, 32'h0,        1);
        add("lw22mis",  32'h22, 32'h0,        0, 3'b010, 1, 32'h0,        1);
        add("f3_011",   32'h20, 32'h0,        0, 3'b011, 1, 32'h0,        1);
        add("f3_110",   32'h20, 32'h0,        0, 3'b110, 1, 32'h0,        1);
        add("st_bu",    32'h20, 32'h0,        1, 3'b100, 1, 32'h0,        1);
        add("st_hu",    32'h20, 32'h0,        1, 3'b101, 1, 32'h0,        1);
        add("lw20b",    32'h20, 32'h0,        0, 3'b010, 1, 32'hCAFE_F00D,0);
        add("lbu23",    32'h23, 32'h0,        0, 3'b100, 1, 32'h0000_00CA,0);
        add("sw00",     32'h0,  32'h11111111, 1, 3'b010, 0, 32'h0,        0);
        add("swtop",    32'h1FFC,32'h77,      1, 3'b010, 0, 32'h0,        0);
        add("lwtop",    32'h1FFC,32'h0,       0, 3'b010, 1, 32'h0000_0077,0);
        add("ledr_st",  32'h1000_0000, 32'hFF, 1, 3'b010, 1, 32'h0,       0);
        add("ledr_ld",  32'h1000_0FFC, 32'h0,  0, 3'b010, 1, 32'hFF,      0);
        add("ledg_sb",  32'h1000_1002, 32'h12, 1, 3'b000, 1, 32'h0,       0);
        add("ledg_ld",  32'h1000_1000, 32'h0,  0, 3'b010, 1, 32'h0012_0000,0);
        add("lcd_sh",   32'h1000_3FFE, 32'hABCD,1,3'b001, 1, 32'h0,       0);
        add("lcd_ld",   32'h1000_3FFC, 32'h0,  0, 3'b010, 1, 32'hABCD_0000,0);
        add("lcd_lhu",  32'h1000_3FFE, 32'h0,  0, 3'b101, 1, 32'h0000_ABCD,0);
        add("um_lw",    32'h2000_0000, 32'h0,  0, 3'b010, 1, 32'h0,       0);
        add("um_sw",    32'h2000_0000, 32'hFFFFFFFF,1,3'b010,1,32'h0,     0);
        add("gap_sw",   32'h1000_2000, 32'hFFFFFFFF,1,3'b010,1,32'h0,     0);
        add("gap_lw",   32'h1000_2000, 32'h0,  0, 3'b010, 1, 32'h0,       0);
        add("dm_end_sw",32'h2000, 32'h99,     1, 3'b010, 1, 32'h0,        0);
        add("dm_end_lw",32'h2000, 32'h0,      0, 3'b010, 1, 32'h0,        0);
        add("lw00",     32'h0,  32'h0,        0, 3'b010, 1, 32'h1111_1111,0);
        add("um_mis",   32'h2000_0001, 32'h0,  0, 3'b010, 1, 32'h0,       1);
        add("lw10d",    32'h10, 32'h0,        0, 3'b010, 1, 32'hDEAD_BEEF,0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        @(negedge clk);
        wren = 1'b0;
        #1;
        check("ledr_out", ledr, 32'h0000_00FF);
        check("ledg_out", ledg, 32'h0012_0000);
        check("lcd_out", lcd, 32'hABCD_0000);

        // Switch synchronizer: two edges of latency, writes ignored.
        addr = 32'h1001_0000; f3 = 3'b010; sw = 32'hA5A5_0001;
        #1;
        check("sw_edge0", ld_data, 32'h1234_5678);
        @(posedge clk); #1;
        check("sw_edge1", ld_data, 32'h1234_5678);
        @(posedge clk); #1;
        check("sw_edge2", ld_data, 32'hA5A5_0001);
        @(negedge clk);
        st_data = 32'h0; wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
        #1;
        check("sw_ro", ld_data, 32'hA5A5_0001);
        check("sw_ro_mis", {31'b0, mis}, 32'h0);

        // Async reset mid-cycle while an LED store is pending.
        @(negedge clk);
        addr = 32'h1000_0000; st_data = 32'h55; wren = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_ledr", ledr, 32'h0);
        check("arst_ledg", ledg, 32'h0);
        check("arst_lcd", lcd, 32'h0);
        @(negedge clk);
        check("rst_store_ledr", ledr, 32'h0);
        addr = 32'h10; st_data = 32'h0; wren = 1'b1;
        @(negedge clk);
        rst = 1'b0; wren = 1'b0;
        #1;
        check("dmem_keep", ld_data, 32'hDEAD_BEEF);
        addr = 32'h1001_0000;
        #1;
        check("sync_clr", ld_data, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
